ffo_scan_ctrl: RTL
==================

Name: ffo_scan_ctrl

Overview:
Sequential set-bit scheduler built around the find-first-one function.
- Accepts an N-bit request mask on a start/ready handshake.
- Emits the position of every set bit, one per accepted beat, MSB first, using a valid/ready output stream.
- Signals completion with a count.
- Sits between a requester mask source (interrupt/request vector) and a consumer that services one index at a time.

Parameters:
- N, 32, mask width; power of two, 4..64.
- W, $clog2(N), width of the position output.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to scan b; sampled only while ready=1.
- b  input  N  mask, captured on the accepted start edge.
- ready  output  1  controller idle, will accept start.
- out_valid  output  1  p/last are valid.
- out_ready  input  1  consumer accepts the current beat.
- p  output  W  leading-zero count of working mask; bit index = N-1-p. Bit N-1 gives p=0.
- last  output  1  current beat is the only remaining set bit.
- done  output  1  one-cycle pulse: scan finished.
- count  output  W+1  set bits emitted in the current/last scan.

Behaviour:
- States: IDLE, EMIT, DONE. Working register m[N-1:0].
- ready = (state==IDLE). Outputs are registered or decoded from registers only; no combinational path from start/out_ready to any output.
- Reset (async, any state): state=IDLE, m=0, count=0, out_valid=0, done=0, p=0, last=0, ready=1.
- IDLE, start=1 at posedge: m<=b, count<=0.
  - b!=0: next state EMIT.
  - b==0: next state DONE.
- start while ready=0 is ignored; no queuing.
- EMIT behaviour:
  - out_valid=1.
  - p = find-first-one position of m, counted from MSB.
  - last = (m has exactly one set bit).
  - First beat appears the cycle after start acceptance (latency 1).
- EMIT, out_ready=1 at posedge:
  - Clear bit N-1-p in m; count<=count+1.
  - last=1: go to DONE. Otherwise stay in EMIT with the next position on the following cycle, so back-to-back beats run at 1 per cycle.
- EMIT, out_ready=0: p, last, out_valid held stable; m and count unchanged.
- DONE: done=1, out_valid=0, ready=0 for exactly one cycle, then IDLE.
- count holds its final value until the next accepted start. Max value N (all ones), which needs W+1 bits.
- Full scan of k set bits with out_ready tied high: start edge, k EMIT cycles, 1 DONE cycle. ready returns k+2 cycles after the start edge.
- b containing X/Z is not supported; result undefined.

Optional Feature:
Macro FFO_SCAN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at posedge in EMIT: next state DONE, with done=1 and count = beats completed so far. A beat accepted on that same edge is counted.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port; a scan always runs to completion.

Test Plan:
1. N=32, b=32'h8000_0001, start, out_ready=1 → beats p=0 last=0, then p=31 last=1; done pulse next cycle, count=2; ready=1 after.
2. b=32'h0000_0000, start → no out_valid; done=1 one cycle after start, count=0; ready back the cycle after.
3. b=32'hFFFF_FFFF, out_ready=1 → 32 consecutive beats p=0..31, last only on p=31; done at cycle 33 after start edge, count=32 (6'b100000).
4. b=32'h0000_00F0, out_ready=0 for 3 cycles after first valid → p=24 held stable 4 cycles; then p=24,25,26,27, last on 27; count=4. Also pulse start mid-scan → ignored.
5. b=32'hFFFF_FFFF, assert reset after 2 accepted beats → immediately out_valid=0, count=0, done=0, ready=1. After release, start with b=32'h0000_0001 → single beat p=31 last=1, count=1.
6. With FFO_SCAN_ABORT_EN: b=32'hF000_0000, abort with out_ready=1 on 2nd beat → done next cycle, count=2, no further beats. Without the macro, the bench checks that all 4 beats complete.

Source files
------------

// File: rtl/ffo_scan_ctrl.sv
// Set-bit scheduler: emits the MSB-first position of each set bit of a captured mask; optional FFO_SCAN_ABORT_EN adds an abort input.
// First beat is one cycle after start; holds p/last while out_ready=0; start is ignored unless ready.
module ffo_scan_ctrl #(
   parameter int N = 32,
   parameter int W = $clog2(N)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] b,
`ifdef FFO_SCAN_ABORT_EN
   input  logic         abort,
`endif
   output logic         ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] p,
   output logic         last,
   output logic         done,
   output logic [W:0]   count
);

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t       state, state_nx;
   logic [N-1:0] m;
   logic [N-1:0] top;
   logic [N-1:0] m_clr;
   logic [W-1:0] lz;
   logic         abort_req;

`ifdef FFO_SCAN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Highest set bit wins: later (higher) iterations overwrite lower ones.
   always_comb begin
      lz  = '0;
      top = '0;
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            lz     = W'(N - 1 - i);
            top    = '0;
            top[i] = 1'b1;
         end
      end
   end

   assign m_clr = m & ~top;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         m     <= '0;
         count <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            m     <= b;
            count <= '0;
         end else if (state == EMIT && out_ready) begin
            m     <= m_clr;
            count <= count + (W+1)'(1);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      ready     = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      p         = lz;
      last      = (m != '0) && ((m & (m - N'(1))) == '0);
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nx = (b == '0) ? DONE : EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if ((out_ready && last) || abort_req) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
